// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM (FETCH/DECODE/execute/writeback) with memory
// wait-state timeout and fault reporting.
// Optional feature: define MIPS_MC_BNE_EN to accept bne (opcode 000101);
// otherwise bne decodes as an illegal instruction.
// Handshake: mem_ready is sampled in FETCH, MEMRD and MEMWR; the access
// completes in the cycle mem_ready=1 while the request outputs are asserted.
module mips_mc_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       halted,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [3:0] alu_control,
    output logic [1:0] fault,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REXEC = 4'd6, S_RWB = 4'd7,
        S_IEXEC = 4'd8, S_IWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
        S_HALT = 4'd15
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_XOR = 4'b0011, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
                           ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_SRA = 4'b1010,
                           ALU_NOR = 4'b1100;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic [1:0] fault_q, fault_next;
    logic       funct_ok, funct_shift, imm_ok, imm_zext, bne_op, timeout;
    logic [3:0] funct_alu, imm_alu;
    logic       ir_write_i, pc_en_i, mem_write_i, reg_write_i;

`ifdef MIPS_MC_BNE_EN
    assign bne_op = (opcode == 6'b000101);
`else
    assign bne_op = 1'b0;
`endif

    // The last permitted wait cycle: one more cycle without mem_ready faults.
    assign timeout = !mem_ready && (wait_cnt == WAIT_LAST);

    // R-type funct decode: legality, ALU op and whether it is a shift.
    always_comb begin
        funct_ok    = 1'b1;
        funct_shift = 1'b0;
        funct_alu   = ALU_AND;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000000: begin funct_alu = ALU_SLL; funct_shift = 1'b1; end
            6'b000010: begin funct_alu = ALU_SRL; funct_shift = 1'b1; end
            6'b000011: begin funct_alu = ALU_SRA; funct_shift = 1'b1; end
            default:   funct_ok = 1'b0;
        endcase
    end

    // I-type arithmetic decode: legality, ALU op and immediate extension.
    always_comb begin
        imm_ok   = 1'b1;
        imm_zext = 1'b0;
        imm_alu  = ALU_ADD;
        case (opcode)
            6'b001000: imm_alu = ALU_ADD;
            6'b001010: imm_alu = ALU_SLT;
            6'b001100: begin imm_alu = ALU_AND; imm_zext = 1'b1; end
            6'b001101: begin imm_alu = ALU_OR;  imm_zext = 1'b1; end
            6'b001110: begin imm_alu = ALU_XOR; imm_zext = 1'b1; end
            default:   imm_ok = 1'b0;
        endcase
    end

    // Next-state and output decode from the registered state.
    always_comb begin
        next_state  = state;
        fault_next  = fault_q;
        iord        = 1'b0;
        ir_write_i  = 1'b0;
        pc_en_i     = 1'b0;
        mem_write_i = 1'b0;
        reg_write_i = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        halted      = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 3'b000;
        pc_src      = 2'b00;
        alu_control = ALU_AND;
        case (state)
            S_FETCH: begin
                alu_src_b   = 3'b001;
                alu_control = ALU_ADD;
                if (mem_ready) begin
                    ir_write_i = 1'b1;
                    pc_en_i    = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_HALT;
                    fault_next = 2'b10;
                end
            end
            S_DECODE: begin
                alu_src_b   = 3'b011;
                alu_control = ALU_ADD;
                if (opcode == 6'b000000 && funct_ok) next_state = S_REXEC;
                else if (opcode == 6'b100011 || opcode == 6'b101011) next_state = S_MEMADR;
                else if (imm_ok) next_state = S_IEXEC;
                else if (opcode == 6'b000100 || bne_op) next_state = S_BRANCH;
                else if (opcode == 6'b000010) next_state = S_JUMP;
                else begin
                    next_state = S_HALT;
                    fault_next = 2'b01;
                end
            end
            S_REXEC, S_RWB: begin
                alu_src_a   = funct_shift ? 2'b10 : 2'b01;
                alu_src_b   = funct_shift ? 3'b101 : 3'b000;
                alu_control = funct_alu;
                if (state == S_REXEC) begin
                    next_state = S_RWB;
                end else begin
                    reg_dst     = 1'b1;
                    reg_write_i = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_IEXEC, S_IWB: begin
                alu_src_a   = 2'b01;
                alu_src_b   = imm_zext ? 3'b100 : 3'b010;
                alu_control = imm_alu;
                if (state == S_IEXEC) begin
                    next_state = S_IWB;
                end else begin
                    reg_write_i = 1'b1;
                    next_state  = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 3'b010;
                alu_control = ALU_ADD;
                next_state  = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                iord        = 1'b1;
                mem_write_i = (state == S_MEMWR);
                if (mem_ready) begin
                    next_state = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timeout) begin
                    next_state = S_HALT;
                    fault_next = 2'b10;
                end
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_i = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b01;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en_i     = bne_op ? ~zero : zero;
                next_state  = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_en_i    = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset gates every write enable immediately, even mid-access.
    assign ir_write  = ir_write_i & ~rst;
    assign pc_en     = pc_en_i & ~rst;
    assign mem_write = mem_write_i & ~rst;
    assign reg_write = reg_write_i & ~rst;
    assign fault     = fault_q;
    assign state_dbg = state;

    // State, wait counter and fault registers; fault only changes on HALT entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
            fault_q  <= 2'b00;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= 8'd0;
            else if ((state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (next_state == S_HALT && state != S_HALT)
                fault_q <= fault_next;
        end
    end
endmodule

// File: tb/tb_mips_mc_controller.sv
// Scenario bench for mips_mc_controller: per-cycle stimulus {rst, mem_ready, zero}
// and expected output vectors are queued together, then replayed and compared.
// Expected vector: {state, iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg,
//                   reg_write, halted, alu_src_a, alu_src_b, pc_src, alu_control, fault}
module tb_mips_mc_controller;
    localparam int W = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write, halted;
    logic [1:0] alu_src_a, pc_src, fault;
    logic [2:0] alu_src_b;
    logic [3:0] alu_control, state_dbg;

    logic [W-1:0] exp_q[$];
    logic [2:0]   stim_q[$];
    int n_vec = 0;
    int n_err = 0;

    // FETCH waiting / FETCH completing / DECODE
    localparam logic [W-1:0] E_F0  = {4'd0, 8'h00, 2'b00, 3'b001, 2'b00, 4'b0010, 2'b00};
    localparam logic [W-1:0] E_F1  = {4'd0, 8'h30, 2'b00, 3'b001, 2'b00, 4'b0010, 2'b00};
    localparam logic [W-1:0] E_DEC = {4'd1, 8'h00, 2'b00, 3'b011, 2'b00, 4'b0010, 2'b00};
    localparam logic [W-1:0] E_MA  = {4'd2, 8'h00, 2'b01, 3'b010, 2'b00, 4'b0010, 2'b00};
    localparam logic [W-1:0] E_MR  = {4'd3, 8'h80, 2'b00, 3'b000, 2'b00, 4'b0000, 2'b00};
    localparam logic [W-1:0] E_MWB = {4'd4, 8'h06, 2'b00, 3'b000, 2'b00, 4'b0000, 2'b00};
    localparam logic [W-1:0] E_MW  = {4'd5, 8'hC0, 2'b00, 3'b000, 2'b00, 4'b0000, 2'b00};
    localparam logic [W-1:0] E_JMP = {4'd11, 8'h10, 2'b00, 3'b000, 2'b10, 4'b0000, 2'b00};
    localparam logic [W-1:0] E_BT  = {4'd10, 8'h10, 2'b01, 3'b000, 2'b01, 4'b0110, 2'b00};
    localparam logic [W-1:0] E_BN  = {4'd10, 8'h00, 2'b01, 3'b000, 2'b01, 4'b0110, 2'b00};
    localparam logic [W-1:0] E_H01 = {4'd15, 8'h01, 2'b00, 3'b000, 2'b00, 4'b0000, 2'b01};
    localparam logic [W-1:0] E_H10 = {4'd15, 8'h01, 2'b00, 3'b000, 2'b00, 4'b0000, 2'b10};

    mips_mc_controller #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .pc_en(pc_en), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .halted(halted), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .fault(fault), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] observed();
        return {state_dbg, iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg,
                reg_write, halted, alu_src_a, alu_src_b, pc_src, alu_control, fault};
    endfunction

    // Driver: queue one cycle of stimulus {rst, mem_ready, zero} with its expectation.
    task automatic put(input logic [2:0] s, input logic [W-1:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Driver: one clean reset cycle, leaving the DUT in FETCH at a falling edge.
    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] e, got;
        do_reset();
        put(3'b110, {4'd0, 8'h00, 2'b00, 3'b001, 2'b00, 4'b0010, 2'b00});
        put(3'b000, E_F0);
        put(3'b000, E_F0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            {rst, mem_ready, zero} = stim_q.pop_front();
            #1; e = exp_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL reset c%0d got %h want %h", i, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [W-1:0] e, got;
        logic [5:0] fn[3] = '{6'b100000, 6'b000011, 6'b100010};
        logic [3:0] op[3] = '{4'b0010, 4'b1010, 4'b0110};
        logic [1:0] a[3]  = '{2'b01, 2'b10, 2'b01};
        logic [2:0] b[3]  = '{3'b000, 3'b101, 3'b000};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = 6'b000000; funct = fn[k];
            put(3'b010, E_F1);
            put(3'b010, E_DEC);
            put(3'b010, {4'd6, 8'h00, a[k], b[k], 2'b00, op[k], 2'b00});
            put(3'b010, {4'd7, 8'h0A, a[k], b[k], 2'b00, op[k], 2'b00});
            put(3'b000, E_F0);
            for (int i = 0; stim_q.size() > 0; i++) begin
                {rst, mem_ready, zero} = stim_q.pop_front();
                #1; e = exp_q.pop_front(); got = observed(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL rtype%0d c%0d got %h want %h", k, i, got, e); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b100011; funct = 6'($urandom_range(0, 63));
        put(3'b010, E_F1);
        put(3'b000, E_DEC);
        put(3'b000, E_MA);
        put(3'b000, E_MR);
        put(3'b000, E_MR);
        put(3'b000, E_MR);
        put(3'b010, E_MR);
        put(3'b000, E_MWB);
        put(3'b000, E_F0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            {rst, mem_ready, zero} = stim_q.pop_front();
            #1; e = exp_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL lw c%0d got %h want %h", i, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump();
        logic [W-1:0] e, got;
        logic [5:0] ops[3] = '{6'b000100, 6'b000100, 6'b000010};
        logic [2:0] st[3]  = '{3'b001, 3'b000, 3'b000};
        logic [W-1:0] ex[3];
        ex[0] = E_BT; ex[1] = E_BN; ex[2] = E_JMP;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = ops[k];
            put(3'b010, E_F1);
            put(3'b000, E_DEC);
            put(st[k], ex[k]);
            put(3'b000, E_F0);
            for (int i = 0; stim_q.size() > 0; i++) begin
                {rst, mem_ready, zero} = stim_q.pop_front();
                #1; e = exp_q.pop_front(); got = observed(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL brjmp%0d c%0d got %h want %h", k, i, got, e); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_itype();
        logic [W-1:0] e, got;
        logic [5:0] ops[3] = '{6'b001000, 6'b001101, 6'b001010};
        logic [2:0] b[3]   = '{3'b010, 3'b100, 3'b010};
        logic [3:0] op[3]  = '{4'b0010, 4'b0001, 4'b0111};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            opcode = ops[k];
            put(3'b010, E_F1);
            put(3'b000, E_DEC);
            put(3'b000, {4'd8, 8'h00, 2'b01, b[k], 2'b00, op[k], 2'b00});
            put(3'b000, {4'd9, 8'h02, 2'b01, b[k], 2'b00, op[k], 2'b00});
            put(3'b000, E_F0);
            for (int i = 0; stim_q.size() > 0; i++) begin
                {rst, mem_ready, zero} = stim_q.pop_front();
                #1; e = exp_q.pop_front(); got = observed(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL itype%0d c%0d got %h want %h", k, i, got, e); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] e, got;
        logic [5:0] ops[2] = '{6'b111111, 6'b000000};
        logic [5:0] fns[2] = '{6'b100000, 6'b111111};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = ops[k]; funct = fns[k];
            put(3'b010, E_F1);
            put(3'b000, E_DEC);
            for (int j = 0; j < 20; j++) put({1'b0, 2'($urandom_range(0, 3))}, E_H01);
            put(3'b110, E_H01);
            put(3'b000, E_F0);
            for (int i = 0; stim_q.size() > 0; i++) begin
                {rst, mem_ready, zero} = stim_q.pop_front();
                #1; e = exp_q.pop_front(); got = observed(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL illegal%0d c%0d got %h want %h", k, i, got, e); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b101011;
        // Ready arriving on the last permitted cycle completes normally.
        put(3'b010, E_F1);
        put(3'b000, E_DEC);
        put(3'b000, E_MA);
        put(3'b000, E_MW);
        put(3'b000, E_MW);
        put(3'b000, E_MW);
        put(3'b010, E_MW);
        put(3'b010, E_F1);
        // Second store never gets ready: four MEMWR cycles, then HALT.
        put(3'b000, E_DEC);
        put(3'b000, E_MA);
        put(3'b000, E_MW);
        put(3'b000, E_MW);
        put(3'b000, E_MW);
        put(3'b000, E_MW);
        put(3'b000, E_H10);
        put(3'b010, E_H10);
        put(3'b000, E_H10);
        for (int i = 0; stim_q.size() > 0; i++) begin
            {rst, mem_ready, zero} = stim_q.pop_front();
            #1; e = exp_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL timeout c%0d got %h want %h", i, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid_access();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b101011;
        put(3'b010, E_F1);
        put(3'b000, E_DEC);
        put(3'b000, E_MA);
        put(3'b000, E_MW);
        put(3'b110, {4'd5, 8'h80, 2'b00, 3'b000, 2'b00, 4'b0000, 2'b00});
        put(3'b000, E_F0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            {rst, mem_ready, zero} = stim_q.pop_front();
            #1; e = exp_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL rstmid c%0d got %h want %h", i, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_bne();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b000101;
        put(3'b010, E_F1);
        put(3'b000, E_DEC);
`ifdef MIPS_MC_BNE_EN
        put(3'b000, E_BT);
        put(3'b000, E_F0);
`else
        put(3'b000, E_H01);
        put(3'b000, E_H01);
`endif
        for (int i = 0; stim_q.size() > 0; i++) begin
            {rst, mem_ready, zero} = stim_q.pop_front();
            #1; e = exp_q.pop_front(); got = observed(); n_vec++;
            if (got !== e) begin n_err++; $display("FAIL bne c%0d got %h want %h", i, got, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_itype();
        test_illegal();
        test_timeout();
        test_rst_mid_access();
        test_bne();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
